// File: rtl/dmem_pkg.sv
// Shared types and sizing for the two-port data-memory arbiter.
// Holds the memory geometry, the requester index type and the request/response records.
package dmem_pkg;

  localparam int DMEM_DEPTH  = 2048;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 32;

  typedef logic [0:0] port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  typedef struct packed {
    logic                   req;
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic                   rvalid;
    logic [DMEM_DATA_W-1:0] rdata;
    logic                   err;
  } dmem_rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant generator.
// On contention the port that did not win last time is granted; rr_last tracks the last winner.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_id_t   gnt_id
);

  port_id_t rr_last_r;

  // One-hot grant from the request pair and the previous winner
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_last_r == PORT1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    gnt_id = port_id_t'(gnt[1]);
  end

  // Last-winner register; reset to port 1 so port 0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_r <= PORT1;
    end else if (|gnt) begin
      rr_last_r <= gnt_id;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory.
// Grants one access per cycle, range-checks it, and routes the 1-cycle response to the owner.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_en,
  output logic              mem_r_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  dmem_req_t         req0_s;
  dmem_req_t         req1_s;
  dmem_rsp_t         rsp0_s;
  dmem_rsp_t         rsp1_s;
  logic [1:0]        gnt_s;
  port_id_t          gnt_id_s;
  logic              gnt_any_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              in_range_s;
  logic [DATA_W-1:0] rdata_s;

  logic              resp_valid_r;
  port_id_t          resp_owner_r;
  logic              resp_err_r;
  logic              resp_is_read_r;

  assign req0_s = '{req: m0_req, we: m0_we, addr: m0_addr, wdata: m0_wdata};
  assign req1_s = '{req: m1_req, we: m1_we, addr: m1_addr, wdata: m1_wdata};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_s.req, req0_s.req}),
    .gnt    (gnt_s),
    .gnt_id (gnt_id_s)
  );

  assign m0_gnt    = gnt_s[0];
  assign m1_gnt    = gnt_s[1];
  assign gnt_any_s = |gnt_s;

  // Payload of the granted port and its range check
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    if (gnt_id_s == PORT1) begin
      sel_we_s    = req1_s.we;
      sel_addr_s  = req1_s.addr;
      sel_wdata_s = req1_s.wdata;
    end else begin
      sel_we_s    = req0_s.we;
      sel_addr_s  = req0_s.addr;
      sel_wdata_s = req0_s.wdata;
    end
    in_range_s = (sel_addr_s < DEPTH_A);
  end

  // Memory controls: only an in-range granted access reaches the array
  always_comb begin
    mem_en    = 1'b0;
    mem_r_w   = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (gnt_any_s && in_range_s) begin
      mem_en    = 1'b1;
      mem_r_w   = sel_we_s;
      mem_addr  = sel_addr_s;
      mem_wdata = sel_wdata_s;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Response bookkeeping captured in the grant cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r   <= 1'b0;
      resp_owner_r   <= PORT0;
      resp_err_r     <= 1'b0;
      resp_is_read_r <= 1'b0;
    end else if (gnt_any_s) begin
      resp_valid_r   <= 1'b1;
      resp_owner_r   <= gnt_id_s;
      resp_err_r     <= ~in_range_s;
      resp_is_read_r <= ~sel_we_s;
    end else begin
      resp_valid_r   <= 1'b0;
      resp_owner_r   <= resp_owner_r;
      resp_err_r     <= 1'b0;
      resp_is_read_r <= 1'b0;
    end
  end

  // Read data is taken straight from the memory so the round trip stays one cycle
  always_comb begin
    rdata_s = {DATA_W{1'b0}};
    if (resp_valid_r && resp_is_read_r && !resp_err_r) begin
      rdata_s = mem_rdata;
    end else begin
      rdata_s = {DATA_W{1'b0}};
    end

    rsp0_s.rvalid = resp_valid_r & (resp_owner_r == PORT0);
    rsp1_s.rvalid = resp_valid_r & (resp_owner_r == PORT1);
    rsp0_s.rdata  = rsp0_s.rvalid ? rdata_s : {DATA_W{1'b0}};
    rsp1_s.rdata  = rsp1_s.rvalid ? rdata_s : {DATA_W{1'b0}};
    rsp0_s.err    = rsp0_s.rvalid & resp_err_r;
    rsp1_s.err    = rsp1_s.rvalid & resp_err_r;
  end

  assign m0_rvalid = rsp0_s.rvalid;
  assign m0_rdata  = rsp0_s.rdata;
  assign m0_err    = rsp0_s.err;
  assign m1_rvalid = rsp1_s.rvalid;
  assign m1_rdata  = rsp1_s.rdata;
  assign m1_err    = rsp1_s.err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and a per-port response scoreboard.
// The driver pushes hand-computed responses; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_r_w;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  logic [31:0] mem [0:2047];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_en(mem_en), .mem_r_w(mem_r_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-ported memory with registered read data
  always @(posedge clk) begin
    if (mem_en && mem_r_w) mem[mem_addr[10:0]] <= mem_wdata;
    mem_rdata <= (mem_en && !mem_r_w) ? mem[mem_addr[10:0]] : 32'd0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon_port(input string nm, input logic rv, input logic [31:0] rd,
                          input logic er, inout exp_t q[$]);
    exp_t e;
    if (rv === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_unexpected_rvalid: got rvalid=1 expected none (cycle %0d)", nm, cyc);
      end else begin
        e = q.pop_front();
        chk({nm, "_latency"}, cyc, e.cyc);
        chk({nm, "_rdata"}, rd, e.rdata);
        chk({nm, "_err"}, {31'd0, er}, {31'd0, e.err});
      end
    end else begin
      chk({nm, "_idle_rdata"}, rd, 32'd0);
      chk({nm, "_idle_err"}, {31'd0, er}, 32'd0);
    end
  endtask

  // Response monitor, sampled on the falling edge
  always @(negedge clk) begin
    mon_port("m0", m0_rvalid, m0_rdata, m0_err, q0);
    mon_port("m1", m1_rvalid, m1_rdata, m1_err, q1);
  end

  task automatic issue(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic [1:0] egnt, input logic [31:0] erd, input logic eerr,
                       input bit push);
    logic        sel;
    logic [31:0] ga;
    logic        gw;
    logic [31:0] gd;
    exp_t        e;
    @(negedge clk);
    #1;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    chk("gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, egnt});
    sel = egnt[1];
    ga  = sel ? a1 : a0;
    gw  = sel ? w1 : w0;
    gd  = sel ? d1 : d0;
    if (egnt != 2'b00) begin
      chk("mem_en", {31'd0, mem_en}, {31'd0, (ga < 32'd2048)});
      if (ga < 32'd2048) begin
        chk("mem_addr", mem_addr, ga);
        chk("mem_r_w", {31'd0, mem_r_w}, {31'd0, gw});
        if (gw) chk("mem_wdata", mem_wdata, gd);
      end
      if (push) begin
        e.cyc = cyc + 1; e.rdata = erd; e.err = eerr;
        if (sel) q1.push_back(e);
        else q0.push_back(e);
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    #1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
    #1;
    chk("idle_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
    chk("idle_mem_r_w", {31'd0, mem_r_w}, 32'd0);
    chk("idle_mem_addr", mem_addr, 32'd0);
    chk("idle_mem_wdata", mem_wdata, 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rvalid"}, {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk({nm, "_rdata0"}, m0_rdata, 32'd0);
    chk({nm, "_rdata1"}, m1_rdata, 32'd0);
    chk({nm, "_err"}, {30'd0, m1_err, m0_err}, 32'd0);
    chk({nm, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    chk({nm, "_mem_addr"}, mem_addr, 32'd0);
    chk({nm, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h1000_0000 + i;

    // Reset state
    @(negedge clk);
    #2;
    chk_all_zero("reset");
    chk("reset_mem_r_w", {31'd0, mem_r_w}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Write then read back addr 5 on port 0
    issue(1, 1, 32'd5, 32'hDEAD_BEEF, 0, 0, 32'd0, 32'd0, 2'b01, 32'd0, 1'b0, 1);
    issue(1, 0, 32'd5, 32'd0,         0, 0, 32'd0, 32'd0, 2'b01, 32'hDEAD_BEEF, 1'b0, 1);

    // Single port-1 access so the next contention favours port 0
    issue(0, 0, 32'd0, 32'd0, 1, 0, 32'd3, 32'd0, 2'b10, 32'h1000_0003, 1'b0, 1);

    // Contention: grants alternate m0, m1, m0, m1
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        issue(1, 0, 32'd10, 32'd0, 1, 0, 32'd20, 32'd0, 2'b01, 32'h1000_000A, 1'b0, 1);
      else
        issue(1, 0, 32'd10, 32'd0, 1, 0, 32'd20, 32'd0, 2'b10, 32'h1000_0014, 1'b0, 1);
    end

    // Out-of-range read and write, then confirm addr 5 untouched
    issue(0, 0, 32'd0,    32'd0,         1, 0, 32'd2048, 32'd0, 2'b10, 32'd0, 1'b1, 1);
    issue(1, 1, 32'd2053, 32'h1234_5678, 0, 0, 32'd0,    32'd0, 2'b01, 32'd0, 1'b1, 1);
    issue(1, 0, 32'd5,    32'd0,         0, 0, 32'd0,    32'd0, 2'b01, 32'hDEAD_BEEF, 1'b0, 1);

    // Streaming reads of addr 0..7
    for (int i = 0; i < 8; i++)
      issue(1, 0, i, 32'd0, 0, 0, 32'd0, 32'd0, 2'b01,
            (i == 5) ? 32'hDEAD_BEEF : 32'h1000_0000 + i, 1'b0, 1);

    // Idle stretch; last winner (port 0) must be remembered
    for (int i = 0; i < 10; i++) idle_cycle();
    issue(1, 0, 32'd8, 32'd0, 1, 0, 32'd9, 32'd0, 2'b10, 32'h1000_0009, 1'b0, 1);
    issue(1, 0, 32'd8, 32'd0, 0, 0, 32'd0, 32'd0, 2'b01, 32'h1000_0008, 1'b0, 1);

    // Reset lands during the response cycle of a granted read
    issue(1, 0, 32'd1, 32'd0, 0, 0, 32'd0, 32'd0, 2'b01, 32'd0, 1'b0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m0_req = 1'b0; m0_addr = 32'd0;
    @(negedge clk);
    #2;
    chk_all_zero("mid_reset");
    @(negedge clk);
    #2;
    chk_all_zero("mid_reset_hold");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // After reset port 0 wins the first contention again
    issue(1, 0, 32'd6, 32'd0, 1, 0, 32'd7, 32'd0, 2'b01, 32'h1000_0006, 1'b0, 1);
    issue(1, 0, 32'd6, 32'd0, 1, 0, 32'd7, 32'd0, 2'b10, 32'h1000_0007, 1'b0, 1);

    for (int i = 0; i < 3; i++) idle_cycle();
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
